// File: rtl/pipe_ctrl_if.sv
// Request/response bundle between the pipeline stages and the central pipeline controller.
// The master side drives stall requests and exception commits. The slave side returns the stall vector and redirect.
interface pipe_ctrl_if;
   logic        stallreq_id;
   logic        stallreq_of;
   logic        stallreq_ex;
   logic        stallreq_mem;
   logic        stallreq_wb;
   logic        excp_valid;
   logic [31:0] excp_type;
   logic [31:0] excp_epc;
   logic [4:0]  stall;
   logic        flush;
   logic        flush_cause;
   logic [31:0] new_pc;
   logic        ctrl_busy;
   logic [1:0]  dbg_state;

   // Requests and excp_* are plain levels, sampled each clock; there is no valid/ready pairing.
   // flush is a one-cycle pulse. flush_cause and new_pc are only meaningful while flush=1.
   modport master (
      output stallreq_id, stallreq_of, stallreq_ex, stallreq_mem, stallreq_wb,
      output excp_valid, excp_type, excp_epc,
      input  stall, flush, flush_cause, new_pc, ctrl_busy, dbg_state
   );

   modport slave (
      input  stallreq_id, stallreq_of, stallreq_ex, stallreq_mem, stallreq_wb,
      input  excp_valid, excp_type, excp_epc,
      output stall, flush, flush_cause, new_pc, ctrl_busy, dbg_state
   );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges stall requests into the stall vector.
// It also sequences exception/ERET flushes with a fixed front-end recovery window.
module pipe_ctrl #(
   parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
   parameter logic [31:0] ERET_TYPE  = 32'h0000000E,
   parameter int unsigned FLUSH_HOLD = 2
) (
   input  logic     clk,
   input  logic     resetn,
   pipe_ctrl_if.slave bus
);
   typedef enum logic [1:0] {RUN = 2'd0, PEND = 2'd1, FLUSH = 2'd2, RECOVER = 2'd3} state_e;

   localparam logic [3:0] HOLD = 4'(FLUSH_HOLD);

   state_e      state_q;
   logic [31:0] type_q, epc_q, new_pc_q;
   logic        flush_q, cause_q;
   logic [3:0]  cnt_q;
   logic [4:0]  encode, stall_d;
   logic        mem_clear;

   // Deepest request wins: freezing 0..j while j+1 runs drops a bubble into j+1.
   always_comb begin
      encode = 5'b00000;
      if (bus.stallreq_wb)       encode = 5'b11111;
      else if (bus.stallreq_mem) encode = 5'b01111;
      else if (bus.stallreq_ex)  encode = 5'b00111;
      else if (bus.stallreq_of)  encode = 5'b00011;
      else if (bus.stallreq_id)  encode = 5'b00001;
   end

   assign mem_clear = !bus.stallreq_mem && !bus.stallreq_wb;

   always_comb begin
      stall_d = 5'b00000;
      case (state_q)
         RUN, PEND: stall_d = encode;
         FLUSH:     stall_d = 5'b00000;
         RECOVER:   stall_d = 5'b00001;
         default:   stall_d = 5'b00000;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= RUN;
         type_q   <= 32'd0;
         epc_q    <= 32'd0;
         new_pc_q <= 32'd0;
         flush_q  <= 1'b0;
         cause_q  <= 1'b0;
         cnt_q    <= 4'd0;
      end else begin
         flush_q <= 1'b0;
         case (state_q)
            RUN: begin
               if (bus.excp_valid) begin
                  type_q <= bus.excp_type;
                  epc_q  <= bus.excp_epc;
                  if (mem_clear) begin
                     // Fast path: redirect comes straight from the inputs, giving flush at t+1.
                     state_q  <= FLUSH;
                     flush_q  <= 1'b1;
                     cause_q  <= (bus.excp_type == ERET_TYPE);
                     new_pc_q <= (bus.excp_type == ERET_TYPE) ? bus.excp_epc : EXC_VECTOR;
                  end else begin
                     state_q <= PEND;
                  end
               end
            end
            PEND: begin
               if (mem_clear) begin
                  state_q  <= FLUSH;
                  flush_q  <= 1'b1;
                  cause_q  <= (type_q == ERET_TYPE);
                  new_pc_q <= (type_q == ERET_TYPE) ? epc_q : EXC_VECTOR;
               end
            end
            FLUSH: begin
               cnt_q   <= HOLD;
               state_q <= (HOLD != 4'd0) ? RECOVER : RUN;
            end
            RECOVER: begin
               cnt_q <= cnt_q - 4'd1;
               if (cnt_q <= 4'd1) state_q <= RUN;
            end
            default: state_q <= RUN;
         endcase
      end
   end

   // Gating stall with resetn lets the stall vector clear during reset even while requests are still asserted.
   assign bus.stall       = resetn ? stall_d : 5'b00000;
   assign bus.flush       = flush_q;
   assign bus.flush_cause = cause_q;
   assign bus.new_pc      = new_pc_q;
   assign bus.ctrl_busy   = (state_q != RUN);
   assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl, run on a default instance (FLUSH_HOLD=2) and a FLUSH_HOLD=0 instance.
// A scoreboard queue holds the expected {flush_cause, new_pc} for every accepted exception.
module tb_pipe_ctrl;
   localparam logic [31:0] EXC_VEC = 32'hBFC00380;
   localparam logic [31:0] ERET    = 32'h0000000E;

   logic clk;
   logic resetn;
   int   checks = 0;
   int   errors = 0;
   int   flush_pulses = 0;
   logic [32:0] exp_q[$];
   logic [32:0] exp0_q[$];

   pipe_ctrl_if b();
   pipe_ctrl_if b0();

   pipe_ctrl #(.EXC_VECTOR(EXC_VEC), .ERET_TYPE(ERET), .FLUSH_HOLD(2)) dut (
      .clk(clk), .resetn(resetn), .bus(b.slave));
   pipe_ctrl #(.EXC_VECTOR(EXC_VEC), .ERET_TYPE(ERET), .FLUSH_HOLD(0)) dut0 (
      .clk(clk), .resetn(resetn), .bus(b0.slave));

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_reqs(input logic [4:0] r);
      b.stallreq_id  = r[0];
      b.stallreq_of  = r[1];
      b.stallreq_ex  = r[2];
      b.stallreq_mem = r[3];
      b.stallreq_wb  = r[4];
   endtask

   function automatic logic [4:0] model_stall(input logic [4:0] r);
      logic [4:0] s;
      s = 5'b0;
      for (int k = 0; k < 5; k++) if (r[k]) s = 5'((6'd1 << (k + 1)) - 6'd1);
      return s;
   endfunction

   // scoreboard: each flush pulse consumes one expected redirect
   always @(negedge clk) begin
      if (resetn && b.flush) begin
         flush_pulses++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL flush_unexpected observed=%0h expected=none", {b.flush_cause, b.new_pc});
         end else begin
            logic [32:0] e;
            e = exp_q.pop_front();
            checks++;
            assert ({b.flush_cause, b.new_pc} === e) else begin
               errors++;
               $error("FAIL flush_redirect observed=%0h expected=%0h", {b.flush_cause, b.new_pc}, e);
            end
         end
      end
      if (resetn && b0.flush) begin
         checks++;
         if (exp0_q.size() == 0) begin
            errors++;
            $error("FAIL flush0_unexpected observed=%0h expected=none", {b0.flush_cause, b0.new_pc});
         end else begin
            logic [32:0] e0;
            e0 = exp0_q.pop_front();
            checks++;
            assert ({b0.flush_cause, b0.new_pc} === e0) else begin
               errors++;
               $error("FAIL flush0_redirect observed=%0h expected=%0h", {b0.flush_cause, b0.new_pc}, e0);
            end
         end
      end
   end

   initial begin
      logic [4:0] r;
      resetn = 1'b0;
      set_reqs(5'b0);
      b.excp_valid = 1'b0; b.excp_type = 32'd0; b.excp_epc = 32'd0;
      b0.stallreq_id = 0; b0.stallreq_of = 0; b0.stallreq_ex = 0;
      b0.stallreq_mem = 0; b0.stallreq_wb = 0;
      b0.excp_valid = 1'b0; b0.excp_type = 32'd0; b0.excp_epc = 32'd0;
      #12;
      check("rst_stall", b.stall, 5'b0);
      check("rst_flush", b.flush, 1'b0);
      check("rst_cause", b.flush_cause, 1'b0);
      check("rst_new_pc", b.new_pc, 32'd0);
      check("rst_busy", b.ctrl_busy, 1'b0);
      resetn = 1'b1;
      tick();

      // stall encode
      set_reqs(5'b00100); #1 check("enc_ex", b.stall, 5'b00111);
      set_reqs(5'b00101); #1 check("enc_ex_id", b.stall, 5'b00111);
      set_reqs(5'b10101); #1 check("enc_wb", b.stall, 5'b11111);
      for (int i = 0; i < 16; i++) begin
         r = 5'($urandom_range(0, 31));
         set_reqs(r); #1 check("enc_rand", b.stall, model_stall(r));
      end
      set_reqs(5'b0);
      tick();

      // ordinary exception, no stall
      b.excp_valid = 1'b1; b.excp_type = 32'h4; b.excp_epc = 32'h1234_5678;
      exp_q.push_back({1'b0, EXC_VEC});
      tick();
      b.excp_valid = 1'b0;
      set_reqs(5'b01000);
      #1 check("exc_flush", b.flush, 1'b1);
      check("exc_flush_stall", b.stall, 5'b00000);
      check("exc_flush_busy", b.ctrl_busy, 1'b1);
      tick();
      check("exc_rec1_stall", b.stall, 5'b00001);
      check("exc_rec1_busy", b.ctrl_busy, 1'b1);
      check("exc_rec1_flush", b.flush, 1'b0);
      tick();
      check("exc_rec2_stall", b.stall, 5'b00001);
      check("exc_rec2_busy", b.ctrl_busy, 1'b1);
      tick();
      check("exc_run_busy", b.ctrl_busy, 1'b0);
      check("exc_run_stall", b.stall, 5'b01111);
      set_reqs(5'b0);
      tick();

      // ERET deferred by a memory stall; second exception ignored in PEND and RECOVER
      b.excp_valid = 1'b1; b.excp_type = ERET; b.excp_epc = 32'h8000_1234;
      set_reqs(5'b01000);
      exp_q.push_back({1'b1, 32'h8000_1234});
      #1 check("eret_run_stall", b.stall, 5'b01111);
      tick();
      b.excp_valid = 1'b1; b.excp_type = 32'h8; b.excp_epc = 32'hDEAD_0000;
      #1 check("pend1_stall", b.stall, 5'b01111);
      check("pend1_busy", b.ctrl_busy, 1'b1);
      check("pend1_flush", b.flush, 1'b0);
      tick();
      b.excp_valid = 1'b0;
      check("pend2_stall", b.stall, 5'b01111);
      check("pend2_flush", b.flush, 1'b0);
      tick();
      set_reqs(5'b0);
      #1 check("pend3_stall", b.stall, 5'b00000);
      check("pend3_flush", b.flush, 1'b0);
      tick();
      check("eret_flush", b.flush, 1'b1);
      tick();
      b.excp_valid = 1'b1; b.excp_type = 32'h8; b.excp_epc = 32'hDEAD_0004;
      #1 check("eret_rec_stall", b.stall, 5'b00001);
      tick();
      b.excp_valid = 1'b0;
      tick();
      check("eret_run_busy", b.ctrl_busy, 1'b0);
      tick();
      tick();
      check("flush_pulse_count", flush_pulses, 2);

      // asynchronous reset in RECOVER
      b.excp_valid = 1'b1; b.excp_type = 32'h4; b.excp_epc = 32'h0;
      exp_q.push_back({1'b0, EXC_VEC});
      tick();
      b.excp_valid = 1'b0;
      tick();
      check("rec_before_rst", b.ctrl_busy, 1'b1);
      #2 resetn = 1'b0;
      #1 check("arst_stall", b.stall, 5'b0);
      check("arst_busy", b.ctrl_busy, 1'b0);
      check("arst_new_pc", b.new_pc, 32'd0);
      tick();
      resetn = 1'b1;
      set_reqs(5'b00010);
      #1 check("post_rst_enc", b.stall, 5'b00011);
      set_reqs(5'b0);
      tick();

      // FLUSH_HOLD=0 instance
      b0.excp_valid = 1'b1; b0.excp_type = 32'h4; b0.excp_epc = 32'h55;
      exp0_q.push_back({1'b0, EXC_VEC});
      tick();
      b0.excp_valid = 1'b0;
      b0.stallreq_of = 1'b1;
      #1 check("h0_flush", b0.flush, 1'b1);
      check("h0_flush_stall", b0.stall, 5'b00000);
      tick();
      check("h0_run_flush", b0.flush, 1'b0);
      check("h0_run_busy", b0.ctrl_busy, 1'b0);
      check("h0_run_stall", b0.stall, 5'b00011);
      b0.stallreq_of = 1'b0;
      tick();

      check("sb_empty", exp_q.size(), 0);
      check("sb0_empty", exp0_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
